// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM stage: opcodes, funct3 access codes and MEM FSM encoding.
package mem_wb_stage_pkg;

    localparam int REG_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_REQ    = 2'd1,
        MEM_WAIT_R = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// Byte-lane steering for stores and byte/half extraction with sign handling for loads.
module lsu_align
    import mem_wb_stage_pkg::*;
(
    input  logic [1:0]           offset,
    input  logic [2:0]           funct3,
    input  logic [REG_WIDTH-1:0] store_data,
    input  logic [REG_WIDTH-1:0] rdata,
    output logic [3:0]           be,
    output logic [REG_WIDTH-1:0] wdata,
    output logic [REG_WIDTH-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lanes: replicate data so the enabled lane always carries it; unknown size writes nothing.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (funct3)
            F3_SB: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Select the addressed byte; halves ignore offset[0].
    always_comb begin
        byte_s = rdata[7:0];
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend to register width; undefined sizes return the whole word.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  load_data = {24'h000000, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LHU:  load_data = {16'h0000, half_s};
            F3_LW:   load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory handshake FSM, front-end stall, and the registered MEM/WB boundary.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
    input  logic [6:0]                EX_MEM_inst_opcode,
    input  logic [2:0]                EX_MEM_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      EX_MEM_reg_write_en,
    input  logic                      EX_MEM_mem_write_en,
    input  logic                      EX_MEM_wb_sel,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [REG_WIDTH-1:0]      dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [REG_WIDTH-1:0]      dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [REG_WIDTH-1:0]      dmem_rdata,
    output logic                      mem_stall,
    output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
    output logic                      MEM_WB_reg_write_en,
    output logic [REG_WIDTH-1:0]      MEM_WB_wb_data,
    output logic [6:0]                MEM_WB_inst_opcode
);

    mem_state_e                state_r, state_next_s;
    logic                      is_load_s, is_store_s, mem_op_s;
    logic                      req_s, complete_s, stall_s;
    logic [REG_WIDTH-1:0]      load_data_s, wb_data_s;
    logic [REG_ADDR_WIDTH-1:0] mem_wb_rd_r;
    logic                      mem_wb_we_r;
    logic [REG_WIDTH-1:0]      mem_wb_data_r;
    logic [6:0]                mem_wb_op_r;

    assign is_load_s  = (EX_MEM_inst_opcode == OPC_LOAD);
    assign is_store_s = (EX_MEM_inst_opcode == OPC_STORE) && EX_MEM_mem_write_en;
    assign mem_op_s   = is_load_s || is_store_s;

    lsu_align u_lsu_align (
        .offset     (EX_MEM_alu_out[1:0]),
        .funct3     (EX_MEM_funct3),
        .store_data (EX_MEM_dataB),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data_s)
    );

    // Handshake state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= MEM_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, request and completion; rvalid only matters while waiting for read data.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            MEM_IDLE: begin
                req_s = mem_op_s;
                if (!mem_op_s) begin
                    state_next_s = MEM_IDLE;
                end else if (!dmem_gnt) begin
                    state_next_s = MEM_REQ;
                end else if (is_store_s) begin
                    complete_s   = 1'b1;
                    state_next_s = MEM_IDLE;
                end else begin
                    state_next_s = MEM_WAIT_R;
                end
            end
            MEM_REQ: begin
                req_s = 1'b1;
                if (!mem_op_s) begin
                    state_next_s = MEM_IDLE;
                end else if (!dmem_gnt) begin
                    state_next_s = MEM_REQ;
                end else if (is_store_s) begin
                    complete_s   = 1'b1;
                    state_next_s = MEM_IDLE;
                end else begin
                    state_next_s = MEM_WAIT_R;
                end
            end
            MEM_WAIT_R: begin
                req_s = 1'b0;
                if (dmem_rvalid) begin
                    complete_s   = 1'b1;
                    state_next_s = MEM_IDLE;
                end else begin
                    state_next_s = MEM_WAIT_R;
                end
            end
            default: begin
                state_next_s = MEM_IDLE;
            end
        endcase
    end

    assign stall_s   = mem_op_s && !complete_s;
    assign wb_data_s = EX_MEM_wb_sel ? load_data_s : EX_MEM_alu_out;

    assign dmem_req  = req_s;
    assign dmem_we   = is_store_s;
    assign dmem_addr = {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
    assign mem_stall = stall_s;

    // MEM/WB register; a stalled cycle inserts a bubble so WB never sees a half-finished access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wb_rd_r   <= {REG_ADDR_WIDTH{1'b0}};
            mem_wb_we_r   <= 1'b0;
            mem_wb_data_r <= {REG_WIDTH{1'b0}};
            mem_wb_op_r   <= 7'd0;
        end else if (stall_s) begin
            mem_wb_rd_r   <= {REG_ADDR_WIDTH{1'b0}};
            mem_wb_we_r   <= 1'b0;
            mem_wb_data_r <= {REG_WIDTH{1'b0}};
            mem_wb_op_r   <= 7'd0;
        end else begin
            mem_wb_rd_r   <= EX_MEM_rd;
            mem_wb_we_r   <= EX_MEM_reg_write_en;
            mem_wb_data_r <= wb_data_s;
            mem_wb_op_r   <= EX_MEM_inst_opcode;
        end
    end

    assign MEM_WB_rd           = mem_wb_rd_r;
    assign MEM_WB_reg_write_en = mem_wb_we_r;
    assign MEM_WB_wb_data      = mem_wb_data_r;
    assign MEM_WB_inst_opcode  = mem_wb_op_r;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM pipeline stage plus MEM/WB register for the 5-stage RISC-V core, consuming the EX/MEM register outputs. Issues load/store requests to data memory over a req/gnt/rvalid handshake, steers byte lanes, and stalls the front of the pipeline while an access is outstanding. Registers rd, write enable and the selected write-back data for the WB stage and for forwarding.

## Interface
- REG_WIDTH, `REG_WIDTH (32), data/address width
- REG_ADDR_WIDTH, `REG_ADDR_WIDTH (5), register index width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- EX_MEM_alu_out  in  REG_WIDTH  effective address, or result; already holds pc_next for JAL
- EX_MEM_dataB  in  REG_WIDTH  store data
- EX_MEM_inst_opcode  in  7  opcode
- EX_MEM_funct3  in  3  access size/sign
- EX_MEM_rd  in  REG_ADDR_WIDTH  destination
- EX_MEM_reg_write_en  in  1  register write enable
- EX_MEM_mem_write_en  in  1  store
- EX_MEM_wb_sel  in  1  1 = memory data, 0 = alu_out
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  REG_WIDTH  word-aligned address {alu_out[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  REG_WIDTH  lane-steered store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  REG_WIDTH  read data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- MEM_WB_rd  out  REG_ADDR_WIDTH
- MEM_WB_reg_write_en  out  1
- MEM_WB_wb_data  out  REG_WIDTH  final write-back value
- MEM_WB_inst_opcode  out  7

## Operation
- Memory op: opcode LOAD (0000011) or STORE (0100011, mem_write_en=1). Any other opcode passes through.
- FSM states:
  - IDLE: dmem_req = mem op.
    - Non-mem op: capture into MEM/WB at the next edge.
    - Store with gnt: done this cycle.
    - Load with gnt: go to WAIT_R.
    - Mem op without gnt: go to REQ.
  - REQ: dmem_req=1; addr/be/wdata/we held stable (EX/MEM frozen).
    - gnt and store: done, go to IDLE.
    - gnt and load: go to WAIT_R.
  - WAIT_R: dmem_req=0.
    - rvalid: capture load data, go to IDLE.
- mem_stall=1 whenever a mem op is present and not completing this cycle. Completing means: store with gnt in IDLE/REQ, or rvalid in WAIT_R.
- While mem_stall=1, MEM/WB loads a bubble: reg_write_en=0, rd=0, opcode=0, wb_data=0.
- Store lanes (off = alu_out[1:0]):
  - SB (000): be=1<<off, wdata=4 copies of dataB[7:0].
  - SH (001): be=off[1]?1100:0011, wdata=2 copies of dataB[15:0].
  - SW (010): be=1111, wdata=dataB.
- Load extract:
  - LB/LBU (000/100): byte at off, sign/zero-extended.
  - LH/LHU (001/101): half at off[1], sign/zero-extended.
  - LW (010): full word.
- Misalignment is not trapped. Half accesses ignore off[0]; word accesses ignore off.
- wb_data = wb_sel ? extracted load data : alu_out.
- Undefined funct3 on a load returns the full word; on a store it gives be=0000 (still handshakes).

## Timing
- Reset: FSM IDLE; all MEM_WB_* outputs 0. dmem_req and mem_stall are 0 while the EX/MEM inputs hold reset values.
- Non-mem op: 1-cycle latency, no stall.
- Store with gnt in first cycle: 1 cycle, no stall. Each cycle without gnt adds 1 stall cycle.
- Load: minimum 2 cycles (gnt, then rvalid ≥1 cycle later), with stall ≥1. rvalid in the same cycle as gnt is illegal.
- rvalid outside WAIT_R is ignored.
- Reset asserted mid-access: FSM returns to IDLE immediately and the pending access is abandoned. The memory side must tolerate a dropped req or rvalid.
- dmem_req, dmem_* and mem_stall are combinational from the EX/MEM inputs and state. The MEM/WB outputs are registered.

## Structure
- Shared header risc_v_defines.vh gains:
  - opcode constants `LOAD and `STORE
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW
  - FSM state encoding MEM_IDLE, MEM_REQ, MEM_WAIT_R
- One sub-module, lsu_align: combinational be/wdata generation and load extraction. The FSM and MEM/WB register live in mem_wb_stage.

## Test plan
- ADD, alu_out=0x0000_1234, rd=5, wb_sel=0 -> next cycle MEM_WB_wb_data=0x1234, rd=5, reg_write_en=1, mem_stall never 1.
- SB, alu_out=0x103, dataB=0xAB, gnt held 0 for 2 cycles -> dmem_req high 3 cycles, dmem_addr=0x100, be=1000, wdata=0xABABABAB, mem_stall=1 for 2 cycles, MEM_WB bubble each cycle.
- LB, alu_out=0x202, rdata=0x0080_0000, gnt immediate, rvalid 2 cycles later -> MEM_WB_wb_data=0xFFFF_FF80, mem_stall=1 for 2 cycles. Same access with LBU -> 0x0000_0080.
- LH, alu_out=0x206, rdata=0x8001_7FFF -> wb_data=0xFFFF_8001. LW, alu_out=0x204 -> wb_data=0x8001_7FFF.
- JAL with alu_out=0x44 (pc_next), wb_sel=0 -> wb_data=0x44, no dmem_req.
- Load pending in WAIT_R, reset_n pulsed low -> state IDLE, MEM_WB_* = 0, mem_stall=0. A later rvalid is ignored.
